// File: rtl/piso_sched_if.sv
// piso_sched_if: requester handshakes and PISO control bundle for piso_sched.
interface piso_sched_if #(parameter int WIDTH = 4);
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data, piso_data;
    logic piso_load, piso_shift_en, frame_active, grant_id, busy;
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input req0_ready, req1_ready, piso_load, piso_data, piso_shift_en, frame_active, grant_id, busy
    );
    modport slave (
        input req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, piso_load, piso_data, piso_shift_en, frame_active, grant_id, busy
    );
endinterface

// File: rtl/piso_sched.sv
// piso_sched: round-robin scheduler feeding two word sources into one external PISO.
module piso_sched #(
    parameter int WIDTH = 4,
    parameter int GAP = 1
) (
    input logic clk,
    input logic clear,
    piso_sched_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [3:0] gcnt;
    logic [WIDTH-1:0] data_q;
    logic ptr, pick1, hs, load_q, shift_q, busy_q, gid_q;
    // ptr=1 favours req1 when both are valid
    always_comb begin
        pick1 = bus.req1_valid && (!bus.req0_valid || ptr);
        bus.req0_ready = state == S_IDLE && bus.req0_valid && !pick1;
        bus.req1_ready = state == S_IDLE && pick1;
    end
    assign hs = bus.req0_ready || bus.req1_ready;
    assign bus.piso_load = load_q;
    assign bus.piso_shift_en = shift_q;
    assign bus.frame_active = shift_q;
    assign bus.busy = busy_q;
    assign bus.grant_id = gid_q;
    assign bus.piso_data = data_q;
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
            cnt <= '0;
            gcnt <= '0;
            data_q <= '0;
            ptr <= 1'b0;
            load_q <= 1'b0;
            shift_q <= 1'b0;
            busy_q <= 1'b0;
            gid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (hs) begin
                    data_q <= pick1 ? bus.req1_data : bus.req0_data;
                    gid_q <= pick1;
                    ptr <= !pick1;
                    load_q <= 1'b1;
                    busy_q <= 1'b1;
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    load_q <= 1'b0;
                    shift_q <= 1'b1;
                    cnt <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        shift_q <= 1'b0;
                        busy_q <= GAP != 0;
                        gcnt <= '0;
                        state <= GAP == 0 ? S_IDLE : S_GAP;
                    end
                end
                default: begin
                    gcnt <= gcnt + 4'd1;
                    if (gcnt == 4'(GAP - 1)) begin
                        busy_q <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
